// File: rtl/window_fetch_ctrl_pkg.sv
// Shared types and frame/window constants for the window fetch path.
// The memory model and the filter import the same defaults.
package win_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  localparam int DEF_D_WIDTH = 8;
  localparam int DEF_IMG_W   = 640;
  localparam int DEF_IMG_H   = 480;
  localparam int DEF_KSIZE   = 7;
  localparam int DEF_MASKLEN = DEF_KSIZE * DEF_KSIZE * DEF_D_WIDTH;

  function automatic int masklen(input int ksize, input int dw);
    return ksize * ksize * dw;
  endfunction

  // Index width for a dimension of n pixels, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/window_fetch_ctrl_if.sv
// Memory read port plus the downstream window valid/ready channel.
interface window_fetch_ctrl_if
  import win_pkg::*;
#(
  parameter int A_WIDTH = 19,
  parameter int MASKLEN = DEF_MASKLEN,
  parameter int ROW_W   = idx_w(DEF_IMG_H),
  parameter int COL_W   = idx_w(DEF_IMG_W)
);
  logic               mem_ren;
  logic [A_WIDTH-1:0] mem_raddr;
  logic [MASKLEN-1:0] mem_rdata;
  logic               win_valid;
  logic               win_ready;
  logic [MASKLEN-1:0] win_data;
  logic [ROW_W-1:0]   win_row;
  logic [COL_W-1:0]   win_col;

  modport master (
    output mem_ren, mem_raddr, win_valid, win_data, win_row, win_col,
    input  mem_rdata, win_ready
  );

  modport slave (
    input  mem_ren, mem_raddr, win_valid, win_data, win_row, win_col,
    output mem_rdata, win_ready
  );
endinterface

// File: rtl/window_fetch_ctrl_skid_fifo.sv
// Two-entry FIFO with a registered head; absorbs reads already in flight
// when the consumer stalls.
module win_skid_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] data,
  output logic [1:0]   occ
);
  logic [W-1:0] slot1;
  logic         do_pop;

  assign do_pop = pop & (occ != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ   <= 2'd0;
      valid <= 1'b0;
      data  <= '0;
      slot1 <= '0;
    end else begin
      case ({push, do_pop})
        2'b10: begin
          if (occ == 2'd0) data  <= push_data;
          else             slot1 <= push_data;
          occ   <= occ + 2'd1;
          valid <= 1'b1;
        end
        2'b01: begin
          data  <= slot1;
          occ   <= occ - 2'd1;
          valid <= (occ != 2'd1);
        end
        2'b11: begin
          // occupancy is unchanged; the head advances
          if (occ == 2'd1) data <= push_data;
          else begin
            data  <= slot1;
            slot1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/window_fetch_ctrl.sv
// Raster-scan read controller for the 7x7 window memory: issues one read per
// window corner and forwards captured windows with (row, col) tags.
module window_fetch_ctrl
  import win_pkg::*;
#(
  parameter int D_WIDTH   = DEF_D_WIDTH,
  parameter int A_WIDTH   = 19,
  parameter int IMG_W     = DEF_IMG_W,
  parameter int IMG_H     = DEF_IMG_H,
  parameter int KSIZE     = DEF_KSIZE,
  parameter int BASE_ADDR = 0,
  parameter int MASKLEN   = masklen(KSIZE, D_WIDTH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done,
  window_fetch_ctrl_if.master bus
);
  localparam int ROW_W = idx_w(IMG_H);
  localparam int COL_W = idx_w(IMG_W);
  localparam int ENT_W = MASKLEN + ROW_W + COL_W;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - KSIZE);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - KSIZE);

  if (KSIZE > IMG_W || KSIZE > IMG_H) begin : g_bad_size
    $error("window_fetch_ctrl: KSIZE exceeds frame dimensions");
  end

  state_t             state;
  logic [ROW_W-1:0]   row, iss_row;
  logic [COL_W-1:0]   col, iss_col;
  logic [A_WIDTH-1:0] addr;
  logic               inflight;
  logic [1:0]         occ;
  logic               pop, issue, win_valid;
  logic [ENT_W-1:0]   head;

  assign pop   = win_valid & bus.win_ready;
  // Never commit more than two windows past what has been consumed.
  assign issue = (state == SCAN) &&
                 (({1'b0, occ} + {2'b00, inflight} - {2'b00, pop}) < 3'd2);

  assign bus.mem_ren   = issue;
  assign bus.mem_raddr = addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      row      <= '0;
      col      <= '0;
      addr     <= '0;
      iss_row  <= '0;
      iss_col  <= '0;
      inflight <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      inflight <= issue;
      done     <= 1'b0;
      if (issue) begin
        iss_row <= row;
        iss_col <= col;
      end
      case (state)
        IDLE: if (start) begin
          state <= SCAN;
          busy  <= 1'b1;
          row   <= '0;
          col   <= '0;
          addr  <= A_WIDTH'(BASE_ADDR);
        end
        SCAN: if (issue) begin
          if (col == LAST_COL) begin
            // skip the KSIZE-1 columns with no full window, plus one
            col  <= '0;
            addr <= addr + A_WIDTH'(KSIZE);
            if (row == LAST_ROW) state <= DRAIN;
            else                 row   <= row + ROW_W'(1);
          end else begin
            col  <= col + COL_W'(1);
            addr <= addr + A_WIDTH'(1);
          end
        end
        DRAIN: if (!inflight && (occ == 2'd0 || (occ == 2'd1 && pop))) begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  win_skid_fifo #(.W(ENT_W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data ({bus.mem_rdata, iss_row, iss_col}),
    .pop       (pop),
    .valid     (win_valid),
    .data      (head),
    .occ       (occ)
  );

  assign bus.win_valid = win_valid;
  assign {bus.win_data, bus.win_row, bus.win_col} = head;
endmodule

// File: tb/tb_window_fetch_ctrl.sv
// Directed bench for window_fetch_ctrl on a 10x9 frame, two base addresses.
module tb_window_fetch_ctrl;
  import win_pkg::*;

  localparam int IW   = 10;
  localparam int IH   = 9;
  localparam int K    = 7;
  localparam int DW   = 8;
  localparam int AW   = 19;
  localparam int ML   = K * K * DW;
  localparam int RW   = idx_w(IH);
  localparam int CW   = idx_w(IW);
  localparam int NC   = IW - K + 1;
  localparam int NWIN = (IH - K + 1) * NC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0, ready = 1'b0;
  logic busy0, busy1, done0, done1;
  int   vec = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  window_fetch_ctrl_if #(.A_WIDTH(AW), .MASKLEN(ML), .ROW_W(RW), .COL_W(CW)) b0 ();
  window_fetch_ctrl_if #(.A_WIDTH(AW), .MASKLEN(ML), .ROW_W(RW), .COL_W(CW)) b1 ();

  window_fetch_ctrl #(.D_WIDTH(DW), .A_WIDTH(AW), .IMG_W(IW), .IMG_H(IH), .KSIZE(K),
                      .BASE_ADDR(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0), .bus(b0.master));

  window_fetch_ctrl #(.D_WIDTH(DW), .A_WIDTH(AW), .IMG_W(IW), .IMG_H(IH), .KSIZE(K),
                      .BASE_ADDR(100)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1), .bus(b1.master));

  function automatic logic [ML-1:0] win_of(input logic [AW-1:0] a);
    logic [ML-1:0] w;
    w = '0;
    for (int i = 0; i < K * K; i++) w[i*DW +: DW] = DW'(int'(a) * 3 + i);
    return w;
  endfunction

  // Memory model: window valid the cycle after ren, zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b0.mem_rdata <= '0;
      b1.mem_rdata <= '0;
    end else begin
      b0.mem_rdata <= b0.mem_ren ? win_of(b0.mem_raddr) : '0;
      b1.mem_rdata <= b1.mem_ren ? win_of(b1.mem_raddr) : '0;
    end
  end

  assign b0.win_ready = ready;
  assign b1.win_ready = ready;

  logic          sel = 1'b0;
  logic          c_ren, c_valid, c_busy, c_done;
  logic [AW-1:0] c_raddr;
  logic [ML-1:0] c_data;
  logic [RW-1:0] c_row;
  logic [CW-1:0] c_col;

  always_comb begin
    if (sel) begin
      c_ren = b1.mem_ren; c_raddr = b1.mem_raddr; c_valid = b1.win_valid;
      c_data = b1.win_data; c_row = b1.win_row; c_col = b1.win_col;
      c_busy = busy1; c_done = done1;
    end else begin
      c_ren = b0.mem_ren; c_raddr = b0.mem_raddr; c_valid = b0.win_valid;
      c_data = b0.win_data; c_row = b0.win_row; c_col = b0.win_col;
      c_busy = busy0; c_done = done0;
    end
  end

  // mode 0: ready=1; 1: 10-cycle stall after 4 windows; 2: random ready;
  // 3: ready=1 with extra start pulses while busy.
  task automatic run_frame(input bit s, input int mode, input int base,
                           output int first_ren, output int first_vld,
                           output int last_iss, output int last_pop, output int done_at);
    int iss, got, cyc, stall, dones, max_out, er, ec;
    bit holding;
    logic [ML-1:0] held;
    iss = 0; got = 0; cyc = 0; stall = 0; dones = 0; max_out = 0;
    holding = 1'b0; held = '0;
    first_ren = -1; first_vld = -1; last_iss = -1; last_pop = -1; done_at = -1;
    sel = s;
    @(negedge clk);
    ready = 1'b1;
    if (s) start1 = 1'b1; else start0 = 1'b1;
    while (cyc < 500 && !(dones > 0 && cyc > done_at + 3)) begin
      @(negedge clk);
      start0 = (mode == 3 && !s && (cyc == 3 || cyc == 8));
      start1 = (mode == 3 &&  s && (cyc == 3 || cyc == 8));
      case (mode)
        1: begin
          ready = !(got >= 4 && stall < 10);
          if (!ready) stall++;
        end
        2: ready = 1'($urandom_range(0, 1));
        default: ready = 1'b1;
      endcase
      #1;
      if (cyc == 0) begin
        vec++;
        if (c_busy !== 1'b1) begin errs++; $display("FAIL busy_in_scan: got %b want 1", c_busy); end
      end
      if (holding) begin
        vec++;
        if (c_valid !== 1'b1 || c_data !== held) begin
          errs++; $display("FAIL hold_stable cyc %0d: valid %b data %h want valid 1 data %h",
                           cyc, c_valid, c_data[31:0], held[31:0]);
        end
      end
      if (c_ren) begin
        er = iss / NC; ec = iss % NC;
        vec++;
        if (c_raddr !== AW'(base + er * IW + ec)) begin
          errs++; $display("FAIL raddr issue %0d: got %0d want %0d", iss, c_raddr, base + er * IW + ec);
        end
        if (first_ren < 0) first_ren = cyc;
        last_iss = cyc;
        iss++;
      end
      if (c_valid && first_vld < 0) first_vld = cyc;
      if (c_valid && ready) begin
        er = got / NC; ec = got % NC;
        vec++;
        if (c_row !== RW'(er) || c_col !== CW'(ec)) begin
          errs++; $display("FAIL tag win %0d: got (%0d,%0d) want (%0d,%0d)", got, c_row, c_col, er, ec);
        end
        vec++;
        if (c_data !== win_of(AW'(base + er * IW + ec))) begin
          errs++; $display("FAIL data win %0d: got %h want %h", got, c_data[31:0],
                           win_of(AW'(base + er * IW + ec)) & 32'hffffffff);
        end
        got++;
        last_pop = cyc;
      end
      holding = c_valid && !ready;
      if (holding) held = c_data;
      if (iss - got > max_out) max_out = iss - got;
      if (c_done) begin dones++; done_at = cyc; end
      cyc++;
    end
    vec++;
    if (iss != NWIN) begin errs++; $display("FAIL issue_count: got %0d want %0d", iss, NWIN); end
    vec++;
    if (got != NWIN) begin errs++; $display("FAIL window_count: got %0d want %0d", got, NWIN); end
    vec++;
    if (dones != 1) begin errs++; $display("FAIL done_count: got %0d want 1", dones); end
    vec++;
    if (max_out > 2) begin errs++; $display("FAIL outstanding: got %0d want <=2", max_out); end
    vec++;
    if (c_busy !== 1'b0) begin errs++; $display("FAIL busy_after_done: got %b want 0", c_busy); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    vec++;
    if ({busy0, done0, b0.mem_ren, b0.win_valid} !== 4'b0) begin
      errs++; $display("FAIL reset_ctrl0: got %b want 0000", {busy0, done0, b0.mem_ren, b0.win_valid});
    end
    vec++;
    if (b0.mem_raddr !== '0 || b0.win_data !== '0 || b0.win_row !== '0 || b0.win_col !== '0) begin
      errs++; $display("FAIL reset_bus0: raddr %0d row %0d col %0d want 0", b0.mem_raddr, b0.win_row, b0.win_col);
    end
    vec++;
    if ({busy1, done1, b1.mem_ren, b1.win_valid} !== 4'b0 || b1.mem_raddr !== '0) begin
      errs++; $display("FAIL reset_dut1: got %b raddr %0d want 0", {busy1, done1, b1.mem_ren, b1.win_valid}, b1.mem_raddr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_small_frame;
    int fr, fv, li, lp, da;
    run_frame(1'b0, 0, 0, fr, fv, li, lp, da);
    vec++;
    if (fr != 0) begin errs++; $display("FAIL first_issue_cycle: got %0d want 0", fr); end
    vec++;
    if (li != fr + NWIN - 1) begin errs++; $display("FAIL back_to_back_issue: last %0d want %0d", li, fr + NWIN - 1); end
    vec++;
    if (da != lp + 1) begin errs++; $display("FAIL done_timing: got %0d want %0d", da, lp + 1); end
  endtask

  task automatic test_latency;
    int fr, fv, li, lp, da;
    run_frame(1'b0, 0, 0, fr, fv, li, lp, da);
    vec++;
    if (fv != fr + 2) begin errs++; $display("FAIL latency: valid at %0d want %0d", fv, fr + 2); end
  endtask

  task automatic test_backpressure;
    int fr, fv, li, lp, da;
    run_frame(1'b0, 1, 0, fr, fv, li, lp, da);
    vec++;
    if (da != lp + 1) begin errs++; $display("FAIL bp_done_timing: got %0d want %0d", da, lp + 1); end
  endtask

  task automatic test_random_ready;
    int fr, fv, li, lp, da;
    run_frame(1'b1, 2, 100, fr, fv, li, lp, da);
  endtask

  task automatic test_reset_mid;
    int got, cyc, fr, fv, li, lp, da;
    sel = 1'b0;
    got = 0; cyc = 0;
    @(negedge clk);
    ready = 1'b1;
    start0 = 1'b1;
    while (got < 5 && cyc < 100) begin
      @(negedge clk);
      start0 = 1'b0;
      #1;
      if (c_valid && ready) got++;
      cyc++;
    end
    vec++;
    if (got != 5) begin errs++; $display("FAIL reset_mid_progress: got %0d want 5", got); end
    #1 rst_n = 1'b0;
    #1;
    vec++;
    if ({c_busy, c_done, c_ren, c_valid} !== 4'b0) begin
      errs++; $display("FAIL reset_mid_ctrl: got %b want 0000", {c_busy, c_done, c_ren, c_valid});
    end
    vec++;
    if (c_raddr !== '0 || c_data !== '0 || c_row !== '0 || c_col !== '0) begin
      errs++; $display("FAIL reset_mid_bus: raddr %0d row %0d col %0d want 0", c_raddr, c_row, c_col);
    end
    repeat (3) begin
      @(negedge clk);
      vec++;
      if (c_done !== 1'b0) begin errs++; $display("FAIL reset_mid_done: got %b want 0", c_done); end
    end
    rst_n = 1'b1;
    run_frame(1'b0, 0, 0, fr, fv, li, lp, da);
    vec++;
    if (fr != 0) begin errs++; $display("FAIL restart_issue_cycle: got %0d want 0", fr); end
  endtask

  task automatic test_start_ignored;
    int fr, fv, li, lp, da;
    run_frame(1'b0, 3, 0, fr, fv, li, lp, da);
  endtask

  initial begin
    test_reset;
    test_small_frame;
    test_latency;
    test_backpressure;
    test_random_ready;
    test_reset_mid;
    test_start_ignored;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
